// File: rtl/energy_monitor_sched.sv
// Sequences one energy-monitor job per spin vector; ENERGY_SCHED_PERF_EN adds a job cycle counter.
// Latency: first request 1 cycle after spin handshake, done_valid_o N+2 cycles after it with zero-wait memory.
// Backpressure: requests capped at MAX_OUTSTANDING credits and held stable until accepted; done holds until done_ready_i.
module energy_monitor_sched #(
  parameter int COUNTER_BITWIDTH = 8,
  parameter int MAX_OUTSTANDING  = 4
) (
  input  logic                        clk_i,
  input  logic                        rst_i,
  input  logic                        en_i,
  input  logic                        config_valid_i,
  output logic                        config_ready_o,
  input  logic [COUNTER_BITWIDTH-1:0] config_counter_i,
  input  logic                        spin_valid_i,
  output logic                        spin_ready_o,
  output logic                        weight_req_valid_o,
  input  logic                        weight_req_ready_i,
  output logic [COUNTER_BITWIDTH-1:0] weight_req_addr_o,
  input  logic                        weight_valid_i,
  output logic                        weight_ready_o,
  output logic                        acc_clear_o,
  output logic                        acc_en_o,
  output logic                        acc_last_o,
  output logic                        done_valid_o,
  input  logic                        done_ready_i,
  output logic                        busy_o,
  output logic [31:0]                 perf_cycles_o
);

  localparam int CW = COUNTER_BITWIDTH + 1;
  localparam int OW = $clog2(MAX_OUTSTANDING + 1);
  localparam logic [OW-1:0] MAX_OUT = OW'(MAX_OUTSTANDING);

  typedef enum logic [1:0] {IDLE, WAIT_SPIN, RUN, DONE} state_t;

  state_t        state;
  logic [CW-1:0] n_q, issued, rcvd;
  logic [OW-1:0] outstanding;
  logic          req_vld;

  logic          cfg_hs, spin_hs, req_hs, rsp_hs, last_rsp;
  logic [CW-1:0] n_nx, issued_nx;
  logic [OW-1:0] out_nx;

  assign config_ready_o     = ~rst_i & ((state == IDLE) | (state == WAIT_SPIN));
  assign spin_ready_o       = (state == WAIT_SPIN) & en_i;
  assign weight_ready_o     = (state == RUN) & (outstanding != '0);
  assign weight_req_valid_o = req_vld;
  assign weight_req_addr_o  = issued[COUNTER_BITWIDTH-1:0];
  assign done_valid_o       = (state == DONE);
  assign busy_o             = (state == RUN) | (state == DONE);

  assign cfg_hs   = config_valid_i & config_ready_o;
  assign spin_hs  = spin_valid_i & spin_ready_o;
  assign req_hs   = req_vld & weight_req_ready_i;
  assign rsp_hs   = weight_valid_i & weight_ready_o;
  assign last_rsp = rsp_hs & ((rcvd + CW'(1)) == n_q);

  assign acc_clear_o = spin_hs;
  assign acc_en_o    = rsp_hs;
  assign acc_last_o  = last_rsp;

  // A row count of zero encodes the full 2^COUNTER_BITWIDTH rows.
  assign n_nx = cfg_hs ? {(config_counter_i == '0), config_counter_i} : n_q;

  always_comb begin
    issued_nx = issued;
    out_nx    = outstanding;
    if (state == RUN) begin
      if (req_hs) issued_nx = issued + CW'(1);
      case ({req_hs, rsp_hs})
        2'b10:   out_nx = outstanding + OW'(1);
        2'b01:   out_nx = outstanding - OW'(1);
        default: out_nx = outstanding;
      endcase
    end
    if (spin_hs) begin
      issued_nx = '0;
      out_nx    = '0;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state       <= IDLE;
      n_q         <= '0;
      issued      <= '0;
      rcvd        <= '0;
      outstanding <= '0;
      req_vld     <= 1'b0;
    end else begin
      n_q         <= n_nx;
      issued      <= issued_nx;
      outstanding <= out_nx;
      case (state)
        IDLE:      if (cfg_hs) state <= WAIT_SPIN;
        WAIT_SPIN: if (spin_hs) begin
                     state <= RUN;
                     rcvd  <= '0;
                   end
        RUN:       if (rsp_hs) begin
                     rcvd <= rcvd + CW'(1);
                     if (last_rsp) state <= DONE;
                   end
        DONE:      if (done_ready_i) state <= WAIT_SPIN;
        default:   state <= IDLE;
      endcase
      // An offered request stays up until accepted, even if en_i drops meanwhile.
      if (req_vld && !weight_req_ready_i)
        req_vld <= 1'b1;
      else
        req_vld <= en_i && (issued_nx < n_nx) && (out_nx < MAX_OUT)
                   && (spin_hs || (state == RUN && !last_rsp));
    end
  end

`ifdef ENERGY_SCHED_PERF_EN
  logic [31:0] perf_q;

  always_ff @(posedge clk_i) begin
    if (rst_i)
      perf_q <= '0;
    else if (spin_hs)
      perf_q <= '0;
    else if ((state == RUN || state == DONE) && perf_q != '1)
      perf_q <= perf_q + 32'd1;
  end

  assign perf_cycles_o = perf_q;
`else
  assign perf_cycles_o = '0;
`endif

endmodule

// File: tb/tb_energy_monitor_sched.sv
// Directed bench for energy_monitor_sched: reset, basic job, credit limit, N=0, stalls, mid-job reset.
module tb_energy_monitor_sched;

  logic        clk_i = 1'b0;
  logic        rst_i = 1'b1;
  logic        en_i = 1'b0;
  logic        config_valid_i = 1'b0;
  logic        config_ready_o;
  logic [7:0]  config_counter_i = '0;
  logic        spin_valid_i = 1'b0;
  logic        spin_ready_o;
  logic        weight_req_valid_o;
  logic        weight_req_ready_i = 1'b0;
  logic [7:0]  weight_req_addr_o;
  logic        weight_valid_i = 1'b0;
  logic        weight_ready_o;
  logic        acc_clear_o, acc_en_o, acc_last_o;
  logic        done_valid_o;
  logic        done_ready_i = 1'b0;
  logic        busy_o;
  logic [31:0] perf_cycles_o;

  int vecs = 0;
  int errs = 0;

  always #5 clk_i = ~clk_i;

  energy_monitor_sched dut (
    .clk_i(clk_i), .rst_i(rst_i), .en_i(en_i),
    .config_valid_i(config_valid_i), .config_ready_o(config_ready_o),
    .config_counter_i(config_counter_i),
    .spin_valid_i(spin_valid_i), .spin_ready_o(spin_ready_o),
    .weight_req_valid_o(weight_req_valid_o), .weight_req_ready_i(weight_req_ready_i),
    .weight_req_addr_o(weight_req_addr_o),
    .weight_valid_i(weight_valid_i), .weight_ready_o(weight_ready_o),
    .acc_clear_o(acc_clear_o), .acc_en_o(acc_en_o), .acc_last_o(acc_last_o),
    .done_valid_o(done_valid_o), .done_ready_i(done_ready_i),
    .busy_o(busy_o), .perf_cycles_o(perf_cycles_o)
  );

  task automatic tick;
    @(posedge clk_i);
    #1;
  endtask

  task automatic do_config(input logic [7:0] n);
    config_valid_i = 1'b1; config_counter_i = n;
    tick();
    config_valid_i = 1'b0;
  endtask

  task automatic do_spin;
    en_i = 1'b1; spin_valid_i = 1'b1;
    tick();
    spin_valid_i = 1'b0;
  endtask

  // Zero-wait memory returning each row one cycle after its request, until done_valid_o.
  task automatic drain(input int pend_in, input int addr_in, input int max_cyc,
                       output int nreq, output int nlast, output int done_cyc, output int addr_err);
    int pend;
    int nxt;
    pend = pend_in; nxt = addr_in;
    nreq = 0; nlast = 0; done_cyc = 0; addr_err = 0;
    for (int c = 1; c <= max_cyc; c++) begin
      weight_req_ready_i = 1'b1; weight_valid_i = (pend > 0); done_ready_i = 1'b0;
      #1;
      if (done_valid_o) begin
        done_cyc = c;
        break;
      end
      if (weight_req_valid_o) begin
        if (weight_req_addr_o != nxt[7:0]) addr_err++;
        nxt++; nreq++; pend++;
      end
      if (acc_en_o) pend--;
      if (acc_last_o) nlast++;
      tick();
    end
    weight_valid_i = 1'b0; weight_req_ready_i = 1'b0;
  endtask

  task automatic test_reset;
    rst_i = 1'b1;
    tick(); tick();
    vecs++; if (config_ready_o !== 1'b0) begin errs++; $display("FAIL rst_cfg_rdy got %0b exp 0", config_ready_o); end
    vecs++; if ({busy_o, done_valid_o, weight_req_valid_o, spin_ready_o, weight_ready_o} !== 5'b0) begin
      errs++; $display("FAIL rst_outs got %b exp 00000", {busy_o, done_valid_o, weight_req_valid_o, spin_ready_o, weight_ready_o}); end
    vecs++; if (perf_cycles_o !== 32'd0) begin errs++; $display("FAIL rst_perf got %0d exp 0", perf_cycles_o); end
    rst_i = 1'b0;
    #1;
    vecs++; if (config_ready_o !== 1'b1) begin errs++; $display("FAIL post_rst_cfg_rdy got %0b exp 1", config_ready_o); end
    vecs++; if (weight_req_addr_o !== 8'd0) begin errs++; $display("FAIL post_rst_addr got %0d exp 0", weight_req_addr_o); end
  endtask

  task automatic test_basic;
    logic [1:9] exp_vld  = 9'b111100000;
    logic [1:9] exp_en   = 9'b011110000;
    logic [1:9] exp_last = 9'b000010000;
    logic [1:9] exp_done = 9'b000001110;
    logic [1:9] exp_busy = 9'b111111110;
    logic due;
    do_config(8'd4);
    en_i = 1'b1; spin_valid_i = 1'b1;
    #1;
    vecs++; if (acc_clear_o !== 1'b1) begin errs++; $display("FAIL basic_clear got %0b exp 1", acc_clear_o); end
    tick();
    spin_valid_i = 1'b0;
    due = 1'b0;
    for (int c = 1; c <= 9; c++) begin
      weight_req_ready_i = 1'b1; weight_valid_i = due; done_ready_i = (c >= 8);
      #1;
      vecs++; if (weight_req_valid_o !== exp_vld[c]) begin errs++; $display("FAIL basic_vld c=%0d got %0b exp %0b", c, weight_req_valid_o, exp_vld[c]); end
      if (exp_vld[c]) begin
        vecs++; if (weight_req_addr_o !== 8'(c-1)) begin errs++; $display("FAIL basic_addr c=%0d got %0d exp %0d", c, weight_req_addr_o, c-1); end
      end
      vecs++; if (acc_en_o !== exp_en[c]) begin errs++; $display("FAIL basic_acc_en c=%0d got %0b exp %0b", c, acc_en_o, exp_en[c]); end
      vecs++; if (acc_last_o !== exp_last[c]) begin errs++; $display("FAIL basic_last c=%0d got %0b exp %0b", c, acc_last_o, exp_last[c]); end
      vecs++; if (done_valid_o !== exp_done[c]) begin errs++; $display("FAIL basic_done c=%0d got %0b exp %0b", c, done_valid_o, exp_done[c]); end
      vecs++; if (busy_o !== exp_busy[c]) begin errs++; $display("FAIL basic_busy c=%0d got %0b exp %0b", c, busy_o, exp_busy[c]); end
      due = weight_req_valid_o & weight_req_ready_i;
      if (c < 9) tick();
    end
    vecs++; if (spin_ready_o !== 1'b1) begin errs++; $display("FAIL basic_spin_rdy got %0b exp 1", spin_ready_o); end
`ifdef ENERGY_SCHED_PERF_EN
    vecs++; if (perf_cycles_o !== 32'd8) begin errs++; $display("FAIL basic_perf got %0d exp 8", perf_cycles_o); end
`else
    vecs++; if (perf_cycles_o !== 32'd0) begin errs++; $display("FAIL basic_perf got %0d exp 0", perf_cycles_o); end
`endif
    weight_req_ready_i = 1'b0; weight_valid_i = 1'b0; done_ready_i = 1'b0;
  endtask

  task automatic test_credit;
    logic [1:9] exp_vld = 9'b111100010;
    int nreq, nlast, dc, aerr;
    do_config(8'd16);
    do_spin();
    for (int c = 1; c <= 9; c++) begin
      weight_req_ready_i = 1'b1; weight_valid_i = (c == 7);
      #1;
      vecs++; if (weight_req_valid_o !== exp_vld[c]) begin errs++; $display("FAIL credit_vld c=%0d got %0b exp %0b", c, weight_req_valid_o, exp_vld[c]); end
      if (exp_vld[c]) begin
        vecs++; if (weight_req_addr_o !== 8'(c < 5 ? c-1 : 4)) begin errs++; $display("FAIL credit_addr c=%0d got %0d", c, weight_req_addr_o); end
      end
      if (c == 7) begin
        vecs++; if (acc_en_o !== 1'b1) begin errs++; $display("FAIL credit_rsp got %0b exp 1", acc_en_o); end
      end
      tick();
    end
    drain(4, 5, 200, nreq, nlast, dc, aerr);
    vecs++; if (nreq !== 11) begin errs++; $display("FAIL credit_nreq got %0d exp 11", nreq); end
    vecs++; if (nlast !== 1 || dc == 0 || aerr != 0) begin errs++; $display("FAIL credit_end last=%0d done_cyc=%0d addr_err=%0d exp 1/nonzero/0", nlast, dc, aerr); end
    done_ready_i = 1'b1; tick(); done_ready_i = 1'b0;
  endtask

  task automatic test_n0;
    int nreq, nlast, dc, aerr;
    do_config(8'd0);
    do_spin();
    drain(0, 0, 400, nreq, nlast, dc, aerr);
    vecs++; if (nreq !== 256) begin errs++; $display("FAIL n0_nreq got %0d exp 256", nreq); end
    vecs++; if (nlast !== 1) begin errs++; $display("FAIL n0_last got %0d exp 1", nlast); end
    vecs++; if (aerr !== 0) begin errs++; $display("FAIL n0_addr got %0d errors exp 0", aerr); end
    vecs++; if (dc !== 258) begin errs++; $display("FAIL n0_latency got %0d exp 258", dc); end
    done_ready_i = 1'b1; tick(); done_ready_i = 1'b0;
  endtask

  task automatic test_stall;
    int nreq, nlast, dc, aerr;
    do_config(8'd8);
    do_spin();
    for (int c = 1; c <= 9; c++) begin
      en_i = (c == 1 || c >= 8);
      weight_req_ready_i = (c >= 5 && c <= 8); weight_valid_i = 1'b0;
      #1;
      vecs++; if (weight_req_valid_o !== (c <= 5 || c == 9)) begin errs++; $display("FAIL stall_vld c=%0d got %0b", c, weight_req_valid_o); end
      if (c <= 5 || c == 9) begin
        vecs++; if (weight_req_addr_o !== (c == 9 ? 8'd1 : 8'd0)) begin errs++; $display("FAIL stall_addr c=%0d got %0d", c, weight_req_addr_o); end
      end
      if (c < 9) tick();
    end
    drain(1, 1, 100, nreq, nlast, dc, aerr);
    vecs++; if (nreq !== 7 || nlast !== 1 || aerr !== 0) begin errs++; $display("FAIL stall_drain nreq=%0d last=%0d aerr=%0d exp 7/1/0", nreq, nlast, aerr); end
    for (int k = 0; k < 5; k++) begin
      spin_valid_i = 1'b1; en_i = 1'b1; done_ready_i = 1'b0;
      #1;
      vecs++; if ({done_valid_o, spin_ready_o, acc_clear_o} !== 3'b100) begin errs++; $display("FAIL stall_done k=%0d got %b exp 100", k, {done_valid_o, spin_ready_o, acc_clear_o}); end
      tick();
    end
    spin_valid_i = 1'b0; done_ready_i = 1'b1;
    tick();
    done_ready_i = 1'b0;
    #1;
    vecs++; if ({done_valid_o, spin_ready_o} !== 2'b01) begin errs++; $display("FAIL stall_after_done got %b exp 01", {done_valid_o, spin_ready_o}); end
  endtask

  task automatic test_reset_midrun;
    int nreq, nlast, dc, aerr;
    do_config(8'd8);
    do_spin();
    weight_req_ready_i = 1'b1; weight_valid_i = 1'b0; tick();
    weight_valid_i = 1'b1; tick();
    weight_req_ready_i = 1'b0;
    #1;
    vecs++; if (acc_en_o !== 1'b1) begin errs++; $display("FAIL midrun_rsp2 got %0b exp 1", acc_en_o); end
    tick();
    weight_valid_i = 1'b0; rst_i = 1'b1;
    tick();
    rst_i = 1'b0;
    #1;
    vecs++; if (config_ready_o !== 1'b1) begin errs++; $display("FAIL midrun_cfg_rdy got %0b exp 1", config_ready_o); end
    vecs++; if ({busy_o, done_valid_o, weight_req_valid_o, spin_ready_o, weight_ready_o, acc_en_o, acc_last_o} !== 7'b0) begin
      errs++; $display("FAIL midrun_outs got %b exp 0000000", {busy_o, done_valid_o, weight_req_valid_o, spin_ready_o, weight_ready_o, acc_en_o, acc_last_o}); end
    vecs++; if (perf_cycles_o !== 32'd0 || weight_req_addr_o !== 8'd0) begin errs++; $display("FAIL midrun_regs perf=%0d addr=%0d exp 0/0", perf_cycles_o, weight_req_addr_o); end
    spin_valid_i = 1'b1; en_i = 1'b1;
    #1;
    vecs++; if ({spin_ready_o, acc_clear_o} !== 2'b00) begin errs++; $display("FAIL unconfig_spin got %b exp 00", {spin_ready_o, acc_clear_o}); end
    tick();
    spin_valid_i = 1'b0;
    #1;
    vecs++; if ({busy_o, weight_req_valid_o} !== 2'b00) begin errs++; $display("FAIL unconfig_busy got %b exp 00", {busy_o, weight_req_valid_o}); end
    do_config(8'd8);
    config_valid_i = 1'b1; config_counter_i = 8'd2; spin_valid_i = 1'b1;
    tick();
    config_valid_i = 1'b0; spin_valid_i = 1'b0;
    drain(0, 0, 50, nreq, nlast, dc, aerr);
    vecs++; if (nreq !== 2 || nlast !== 1 || dc !== 4) begin errs++; $display("FAIL same_cycle_cfg nreq=%0d last=%0d done_cyc=%0d exp 2/1/4", nreq, nlast, dc); end
    done_ready_i = 1'b1; tick(); done_ready_i = 1'b0;
  endtask

  initial begin
    test_reset();
    test_basic();
    test_credit();
    test_n0();
    test_stall();
    test_reset_midrun();
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

endmodule

// File: doc/energy_monitor_sched.md
# energy_monitor_sched

Scheduler that sequences one energy-monitor evaluation per spin vector: it holds the configured row count, accepts a spin vector, issues weight-row fetch requests under an outstanding-credit limit, counts returned rows, drives the accumulator control strobes, and reports completion through a done handshake. It sits between the spin/weight streaming interfaces and the step counter / accumulator datapath of the energy monitor.

## Interface
- `COUNTER_BITWIDTH`, 8: width of row index and row counters; a job has up to 2^COUNTER_BITWIDTH rows.
- `MAX_OUTSTANDING`, 4: maximum issued-but-unreturned weight requests, ≥1.
- `clk_i` in 1: clock.
- `rst_i` in 1: synchronous, active-high reset.
- `en_i` in 1: enable; gates new request issue and spin acceptance only.
- `config_valid_i` in 1 / `config_ready_o` out 1: row-count configuration handshake.
- `config_counter_i` in COUNTER_BITWIDTH: row count N; 0 encodes 2^COUNTER_BITWIDTH.
- `spin_valid_i` in 1 / `spin_ready_o` out 1: spin vector handshake (starts a job).
- `weight_req_valid_o` out 1 / `weight_req_ready_i` in 1: weight-row request handshake.
- `weight_req_addr_o` out COUNTER_BITWIDTH: row index of current request.
- `weight_valid_i` in 1 / `weight_ready_o` out 1: weight-row response handshake.
- `acc_clear_o` out 1: one-cycle pulse, clears accumulator.
- `acc_en_o` out 1: accumulate strobe, equals response handshake.
- `acc_last_o` out 1: high with acc_en_o on row N's response.
- `done_valid_o` out 1 / `done_ready_i` in 1: job completion handshake.
- `busy_o` out 1: state is RUN or DONE.
- `perf_cycles_o` out 32: job cycle count (see Configuration).

## Operation
- States: IDLE (unconfigured), WAIT_SPIN, RUN, DONE.
- IDLE: config_ready_o=1; config handshake stores N, → WAIT_SPIN.
- WAIT_SPIN: config_ready_o=1 (reconfiguration allowed, overwrites N, stays); spin_ready_o=en_i. Spin handshake → RUN; issue counter, response counter, outstanding counter cleared; acc_clear_o pulses in the handshake cycle. Config and spin handshakes in the same cycle: both taken, job uses the new N.
- RUN: config_ready_o=0, spin_ready_o=0.
  - weight_req_valid_o asserts when issued<N, outstanding<MAX_OUTSTANDING, en_i=1. Once asserted it, and weight_req_addr_o, hold stable until weight_req_ready_i, regardless of en_i.
  - weight_req_addr_o = issued count (0..N-1); issued increments on request handshake.
  - weight_ready_o = (outstanding>0); responses with outstanding=0 are not accepted.
  - Outstanding: +1 on request handshake, −1 on response handshake, unchanged when both occur in one cycle.
  - On the N-th response handshake: acc_last_o=1, → DONE.
- DONE: done_valid_o=1 until done_ready_i; on handshake → WAIT_SPIN. N retained.
- Counters are COUNTER_BITWIDTH+1 bits so N=2^COUNTER_BITWIDTH is representable; no wrap within a job.

## Timing
- While rst_i high and in the first cycle after: state IDLE, N=0, all counters 0; every output 0 except config_ready_o, which is 1 from the first cycle after reset.
- Reset mid-job: job discarded, next cycle IDLE; N must be reconfigured.
- First weight_req_valid_o: cycle after spin handshake (registered).
- Back-to-back requests: one per cycle while credits allow. Credit freed by a response is usable the next cycle.
- done_valid_o: cycle after the last response handshake.
- spin_ready_o: earliest the cycle after the done handshake.
- Minimum job latency (spin handshake → done_valid_o), zero-wait memory with single-cycle responses: N+2 cycles.

## Configuration
- `ENERGY_SCHED_PERF_EN` defined: 32-bit counter clears on spin handshake, increments every cycle in RUN and DONE, and freezes at the done handshake. perf_cycles_o shows this value and holds it until the next spin handshake. The counter saturates at 2^32−1.
- Not defined: counter logic absent; perf_cycles_o tied to 0.

## Test plan
- Basic: config N=4, spin, zero-wait memory with 1-cycle responses -> addrs 0,1,2,3 on consecutive cycles; acc_last_o on 4th response; done_valid_o 6 cycles after spin handshake.
- Credit limit: MAX_OUTSTANDING=4, N=16, responses withheld -> exactly 4 requests, then valid low. One response releases one request the next cycle.
- N=0 encoding: config 0 with COUNTER_BITWIDTH=8 -> 256 requests (addr 0..255), single acc_last_o, then done.
- Stalls: en_i low for 3 cycles while weight_req_valid_o=1 and ready=0 -> valid/addr held stable. No new request asserts while en_i low. done_ready_i held low 5 cycles -> done_valid_o holds and spin_ready_o=0.
- Reset mid-RUN after 2 of 8 responses -> all outputs 0 except config_ready_o=1, state IDLE. A spin offered before config is not accepted.
- Perf (ENERGY_SCHED_PERF_EN): basic scenario with done_ready_i delayed 2 cycles -> perf_cycles_o=8 after the done handshake. Without the macro -> perf_cycles_o=0 throughout.
